uart_baud_gen: RTL and testbench

Parametrised, runtime-programmable UART baud-rate generator for the UART TX/RX blocks, fed from Sys_CLK.
- Produces a single-cycle oversample tick (Os_Tick), a bit-rate tick (Baud_Tick), a mid-bit sample tick (Mid_Tick) and a 50%-duty baud-rate square wave (Uart_CLK).
- Adds a fractional divisor for low rate error, glitch-free divisor reload, and a Resync input that lets RX align bit phase to the start-bit edge.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_frac_div.sv | 61 ++++++
 rtl/uart_baud_gen.sv | 53 +++++
 tb/tb_uart_baud_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, standard baud divisor table and phase-width helper
package uart_pkg;
  localparam int DEFAULT_DIV = 27;
  localparam int DEFAULT_FRAC = 2;
  typedef enum logic [2:0] {
    B9600, B19200, B38400, B57600, B115200, B230400, B460800, B921600
  } baud_e;
  typedef struct packed {
    logic [15:0] div_int;
    logic [3:0]  div_frac;
  } baud_cfg_t;
  // 50 MHz clock, 16x oversampling, fraction in 1/16 cycle, indexed by baud_e
  localparam baud_cfg_t BAUD_TABLE [8] = '{
    '{16'd325, 4'd8}, '{16'd162, 4'd12}, '{16'd81, 4'd6}, '{16'd54, 4'd4},
    '{16'd27, 4'd2}, '{16'd13, 4'd9}, '{16'd6, 4'd13}, '{16'd3, 4'd6}
  };
  function automatic int phase_w(int os);
    return $clog2(os);
  endfunction
endpackage

// File: rtl/uart_frac_div.sv
// uart_frac_div: fractional clock divider with shadowed divisor and oversample tick
module uart_frac_div #(
  parameter int DIV_W = 16,
  parameter int FRAC_W = 4,
  parameter int DEFAULT_DIV = 27,
  parameter int DEFAULT_FRAC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              resync,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick_edge,
  output logic              os_tick
);
  logic [DIV_W-1:0] cnt, act_int, shd_int;
  logic [FRAC_W-1:0] acc, act_frac, shd_frac;
  logic carry, pending, apply;
  logic [DIV_W:0] last;
  // terminal count is act_int+carry-1; >= keeps a shrunk divisor from stalling the counter
  always_comb begin
    last = {1'b0, act_int} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);
    tick_edge = en && !resync && ({1'b0, cnt} >= last);
    apply = pending && (tick_edge || !en);
  end
  // counter, fractional accumulator and shadow divisor handover at period boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      carry <= 1'b0;
      os_tick <= 1'b0;
      pending <= 1'b0;
      act_int <= DIV_W'(DEFAULT_DIV);
      act_frac <= FRAC_W'(DEFAULT_FRAC);
      shd_int <= DIV_W'(DEFAULT_DIV);
      shd_frac <= FRAC_W'(DEFAULT_FRAC);
    end else begin
      os_tick <= tick_edge;
      if (resync) begin
        cnt <= '0;
        acc <= '0;
        carry <= 1'b0;
      end else if (tick_edge) begin
        cnt <= '0;
        {carry, acc} <= {1'b0, acc} + {1'b0, act_frac};
      end else if (en) cnt <= cnt + DIV_W'(1);
      if (apply) begin
        act_int <= shd_int;
        act_frac <= shd_frac;
      end
      if (load) begin
        shd_int <= (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
        shd_frac <= div_frac;
        pending <= 1'b1;
      end else if (apply) pending <= 1'b0;
    end
  end
endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable UART baud generator with oversample, bit and mid-bit ticks
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int FRAC_W = 4,
  parameter int OVERSAMPLE = 16,
  parameter int DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
  parameter int DEFAULT_FRAC = uart_pkg::DEFAULT_FRAC
) (
  input  logic                              Sys_CLK,
  input  logic                              Sys_RST,
  input  logic                              En,
  input  logic [DIV_W-1:0]                  Div_Int,
  input  logic [FRAC_W-1:0]                 Div_Frac,
  input  logic                              Div_Load,
  input  logic                              Resync,
  output logic                              Os_Tick,
  output logic                              Baud_Tick,
  output logic                              Mid_Tick,
  output logic                              Uart_CLK,
  output logic [phase_w(OVERSAMPLE)-1:0]    Os_Phase,
  output logic                              Cfg_Err
);
  localparam int PW = phase_w(OVERSAMPLE);
  logic tick_edge;
  logic [PW-1:0] phase, phase_nxt;
  uart_frac_div #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .DEFAULT_DIV(DEFAULT_DIV), .DEFAULT_FRAC(DEFAULT_FRAC)
  ) u_div (
    .clk(Sys_CLK), .rst(Sys_RST), .en(En), .resync(Resync), .load(Div_Load),
    .div_int(Div_Int), .div_frac(Div_Frac), .tick_edge(tick_edge), .os_tick(Os_Tick)
  );
  // oversample phase advances on each tick; resync restarts the bit
  always_comb phase_nxt = Resync ? '0 : tick_edge ? phase + PW'(1) : phase;
  // phase register, bit/mid-bit decode, square wave from phase MSB, sticky config error
  always_ff @(posedge Sys_CLK) begin
    if (Sys_RST) begin
      phase <= '0;
      Baud_Tick <= 1'b0;
      Mid_Tick <= 1'b0;
      Uart_CLK <= 1'b0;
      Cfg_Err <= 1'b0;
    end else begin
      phase <= phase_nxt;
      Baud_Tick <= tick_edge && phase == PW'(OVERSAMPLE-1);
      Mid_Tick <= tick_edge && phase == PW'(OVERSAMPLE/2-1);
      Uart_CLK <= phase_nxt[PW-1];
      if (Div_Load) Cfg_Err <= Div_Int < DIV_W'(2);
    end
  end
  assign Os_Phase = phase;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed self-checking bench for uart_baud_gen
module tb_uart_baud_gen;
  logic clk = 0, rst = 1, en = 0, load = 0, resync = 0;
  logic [15:0] div_int = 0;
  logic [3:0] div_frac = 0;
  logic os_tick, baud_tick, mid_tick, uart_clk, cfg_err;
  logic [3:0] os_phase;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  uart_baud_gen dut (
    .Sys_CLK(clk), .Sys_RST(rst), .En(en), .Div_Int(div_int), .Div_Frac(div_frac),
    .Div_Load(load), .Resync(resync), .Os_Tick(os_tick), .Baud_Tick(baud_tick),
    .Mid_Tick(mid_tick), .Uart_CLK(uart_clk), .Os_Phase(os_phase), .Cfg_Err(cfg_err)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic next_tick(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!os_tick && n < 500);
  endtask

  task automatic do_reset();
    en = 0; load = 0; resync = 0; rst = 1;
    cyc();
    rst = 0;
  endtask

  task automatic load_idle(input int di, input int df);
    en = 0; div_int = 16'(di); div_frac = 4'(df); load = 1;
    cyc();
    load = 0;
    cyc();
  endtask

  task automatic test_reset();
    int n;
    cyc();
    do_reset();
    checks++; if ({os_tick, baud_tick, mid_tick, uart_clk, cfg_err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b want=00000", {os_tick, baud_tick, mid_tick, uart_clk, cfg_err}); end
    checks++; if (os_phase !== 4'd0) begin failures++; $display("FAIL reset_phase got=%0d want=0", os_phase); end
    en = 1;
    next_tick(n);
    checks++; if (n !== 27) begin failures++; $display("FAIL reset_first_tick got=%0d want=27", n); end
  endtask

  task automatic test_int_div();
    int os_cnt = 0, baud_cnt = 0, first_baud = 0, first_mid = 0, last_mid = 0, hi = 0, bad = 0, ph40 = 0;
    do_reset();
    load_idle(4, 0);
    en = 1;
    for (int i = 1; i <= 128; i++) begin
      cyc();
      if (os_tick) os_cnt++;
      if (baud_tick) begin
        baud_cnt++;
        if (first_baud == 0) first_baud = i;
        if (!os_tick) bad++;
      end
      if (mid_tick) begin
        if (first_mid == 0) first_mid = i;
        last_mid = i;
      end
      if (uart_clk) hi++;
      if (i == 40) ph40 = int'(os_phase);
    end
    checks++; if (os_cnt !== 32) begin failures++; $display("FAIL int_os_count got=%0d want=32", os_cnt); end
    checks++; if (first_baud !== 64) begin failures++; $display("FAIL int_first_baud got=%0d want=64", first_baud); end
    checks++; if (baud_cnt !== 2) begin failures++; $display("FAIL int_baud_count got=%0d want=2", baud_cnt); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL int_baud_without_os got=%0d want=0", bad); end
    checks++; if (first_mid !== 32) begin failures++; $display("FAIL int_first_mid got=%0d want=32", first_mid); end
    checks++; if (last_mid !== 96) begin failures++; $display("FAIL int_mid_after_baud got=%0d want=96", last_mid); end
    checks++; if (hi !== 64) begin failures++; $display("FAIL int_uart_clk_high got=%0d want=64", hi); end
    checks++; if (ph40 !== 10) begin failures++; $display("FAIL int_phase_at_40 got=%0d want=10", ph40); end
  endtask

  task automatic test_frac_div();
    int t[20];
    int cnt = 0;
    do_reset();
    load_idle(4, 8);
    en = 1;
    for (int i = 1; i <= 72; i++) begin
      cyc();
      if (os_tick && cnt < 20) begin
        t[cnt] = i;
        cnt++;
      end
    end
    checks++; if (cnt !== 16) begin failures++; $display("FAIL frac_count got=%0d want=16", cnt); end
    checks++; if (t[0] !== 4) begin failures++; $display("FAIL frac_first got=%0d want=4", t[0]); end
    checks++; if (t[1] - t[0] !== 4) begin failures++; $display("FAIL frac_gap2 got=%0d want=4", t[1] - t[0]); end
    checks++; if (t[2] - t[1] !== 5) begin failures++; $display("FAIL frac_gap3 got=%0d want=5", t[2] - t[1]); end
    checks++; if (t[3] - t[2] !== 4) begin failures++; $display("FAIL frac_gap4 got=%0d want=4", t[3] - t[2]); end
    checks++; if (t[15] !== 71) begin failures++; $display("FAIL frac_tick16 got=%0d want=71", t[15]); end
  endtask

  task automatic test_load();
    int n;
    do_reset();
    load_idle(4, 0);
    en = 1;
    next_tick(n);
    cyc();
    cyc();
    div_int = 16'd10; load = 1;
    cyc();
    load = 0;
    cyc();
    checks++; if (os_tick !== 1'b1) begin failures++; $display("FAIL load_period_kept got=%b want=1", os_tick); end
    next_tick(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL load_new_period1 got=%0d want=10", n); end
    next_tick(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL load_new_period2 got=%0d want=10", n); end
  endtask

  task automatic test_resync();
    int n, cnt, i;
    logic got;
    do_reset();
    load_idle(4, 0);
    en = 1;
    i = 0;
    do begin
      cyc();
      i++;
    end while (!(os_tick && os_phase == 4'd9) && i < 200);
    checks++; if (os_phase !== 4'd9) begin failures++; $display("FAIL resync_reach_phase9 got=%0d want=9", os_phase); end
    repeat (3) cyc();
    resync = 1;
    cyc();
    resync = 0;
    checks++; if (os_tick !== 1'b0) begin failures++; $display("FAIL resync_no_tick got=%b want=0", os_tick); end
    checks++; if (os_phase !== 4'd0) begin failures++; $display("FAIL resync_phase got=%0d want=0", os_phase); end
    next_tick(n);
    checks++; if (n !== 4) begin failures++; $display("FAIL resync_first_tick got=%0d want=4", n); end
    cnt = 1;
    got = mid_tick;
    for (int k = 0; k < 100 && !got; k++) begin
      cyc();
      if (os_tick) cnt++;
      got = mid_tick;
    end
    checks++; if (cnt !== 8 || !got) begin failures++; $display("FAIL resync_mid got=%0d ticks (seen=%b) want=8", cnt, got); end
  endtask

  task automatic test_cfg_err();
    int n;
    do_reset();
    load_idle(1, 0);
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_set got=%b want=1", cfg_err); end
    en = 1;
    next_tick(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL cfg_clamped_period1 got=%0d want=2", n); end
    next_tick(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL cfg_clamped_period2 got=%0d want=2", n); end
    div_int = 16'd5; load = 1;
    cyc();
    load = 0;
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_clear got=%b want=0", cfg_err); end
    next_tick(n);
    checks++; if (n !== 1) begin failures++; $display("FAIL cfg_old_period_end got=%0d want=1", n); end
    next_tick(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL cfg_new_period got=%0d want=5", n); end
  endtask

  task automatic test_rst_en();
    int n, ticks = 0;
    do_reset();
    load_idle(4, 0);
    en = 1;
    repeat (42) cyc();
    checks++; if (uart_clk !== 1'b1 || os_phase !== 4'd10) begin failures++; $display("FAIL rst_pre_state got=%b/%0d want=1/10", uart_clk, os_phase); end
    rst = 1;
    cyc();
    rst = 0;
    checks++; if ({os_tick, baud_tick, mid_tick, uart_clk, cfg_err} !== 5'b0 || os_phase !== 4'd0) begin failures++; $display("FAIL rst_mid_outputs got=%b/%0d want=00000/0", {os_tick, baud_tick, mid_tick, uart_clk, cfg_err}, os_phase); end
    next_tick(n);
    checks++; if (n !== 27) begin failures++; $display("FAIL rst_default_period got=%0d want=27", n); end
    repeat (10) cyc();
    en = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (os_tick) ticks++;
    end
    checks++; if (ticks !== 0 || os_phase !== 4'd1) begin failures++; $display("FAIL en_low_hold got=%0d ticks phase %0d want=0 ticks phase 1", ticks, os_phase); end
    en = 1;
    next_tick(n);
    checks++; if (10 + 7 + n !== 34) begin failures++; $display("FAIL en_low_delay got=%0d want=34", 10 + 7 + n); end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_int_div();
    test_frac_div();
    test_load();
    test_resync();
    test_cfg_err();
    test_rst_en();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
